// File: rtl/matmul_pkg.sv
// Shared constants, loader state type and element packing helper for the 2x2 matmul operand loader.
package matmul_pkg;

    localparam int ELEM_W    = 2;
    localparam int NUM_ELEMS = 8;
    localparam int MAT_W     = 4 * ELEM_W;
    localparam int CNT_W     = $clog2(NUM_ELEMS);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } load_state_t;

    // Low bit of element k inside its matrix word; element 0 of each matrix sits in the MSBs.
    function automatic int elem_offset(input int k);
        return MAT_W - ELEM_W - (k % 4) * ELEM_W;
    endfunction

endpackage

// File: rtl/matmul_operand_loader_if.sv
// Element stream in, packed operand pair out; master is the environment side, slave is the loader.
interface matmul_operand_loader_if;
    import matmul_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_elem;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [MAT_W-1:0]  out_a;
    logic [MAT_W-1:0]  out_b;

    modport master (
        output in_valid, in_elem, in_last, out_ready,
        input  in_ready, out_valid, out_a, out_b
    );

    modport slave (
        input  in_valid, in_elem, in_last, out_ready,
        output in_ready, out_valid, out_a, out_b
    );

endinterface

// File: rtl/matload_frame_ctrl.sv
// Element counter and frame delimiting check; frame_err pulses the cycle after a malformed final accept.
module matload_frame_ctrl
    import matmul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic             in_last,
    output logic [CNT_W-1:0] count,
    output logic             frame_done,
    output logic             frame_err
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             frame_err_reg;
    logic             frame_err_next;
    logic             last_slot;

    assign last_slot  = (count_reg == CNT_W'(NUM_ELEMS - 1));
    assign frame_done = accept && last_slot && in_last;

    always_comb begin
        count_next     = count_reg;
        frame_err_next = 1'b0;
        if (accept) begin
            // Either a proper end or a delimiting error restarts the frame.
            if (last_slot || in_last) begin
                count_next = '0;
            end else begin
                count_next = count_reg + 1'b1;
            end
            frame_err_next = (last_slot != in_last);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg     <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign count     = count_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: rtl/matmul_operand_loader.sv
// Assembles 8 serial elements into packed A/B operand words behind a valid/ready output.
// Optional staging buffer for back-to-back frames: define MATLOAD_DBUF_EN.
module matmul_operand_loader
    import matmul_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    matmul_operand_loader_if.slave   lif,
    output logic                     frame_err
);

    load_state_t      state_reg;
    load_state_t      state_next;
    logic [MAT_W-1:0] a_asm_reg;
    logic [MAT_W-1:0] a_asm_next;
    logic [MAT_W-1:0] b_asm_reg;
    logic [MAT_W-1:0] b_asm_next;
    logic [MAT_W-1:0] out_a_reg;
    logic [MAT_W-1:0] out_b_reg;
    logic [CNT_W-1:0] count;
    logic             frame_done;
    logic             accept;
    logic             handshake;
    logic             take_new;
    logic             take_staged;
    logic [3:0]       a_slot_we;
    logic [3:0]       b_slot_we;

`ifdef MATLOAD_DBUF_EN
    logic             staged_reg;
    logic             staged_next;

    assign lif.in_ready = !rst && ((state_reg == LOAD) || !staged_reg);
`else
    assign lif.in_ready = !rst && (state_reg == LOAD);
`endif

    assign accept    = lif.in_valid && lif.in_ready;
    assign handshake = (state_reg == HOLD) && lif.out_ready;

    matload_frame_ctrl u_frame_ctrl (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .accept     (accept),
        .in_last    (lif.in_last),
        .count      (count),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    // The "next" words already contain the element accepted this cycle, so a completing
    // frame can be copied to the output without waiting for the assembly registers.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign a_slot_we[gi] = accept && (count == CNT_W'(gi));
            assign b_slot_we[gi] = accept && (count == CNT_W'(gi + 4));
            assign a_asm_next[elem_offset(gi) +: ELEM_W] =
                a_slot_we[gi] ? lif.in_elem : a_asm_reg[elem_offset(gi) +: ELEM_W];
            assign b_asm_next[elem_offset(gi) +: ELEM_W] =
                b_slot_we[gi] ? lif.in_elem : b_asm_reg[elem_offset(gi) +: ELEM_W];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        take_new    = 1'b0;
        take_staged = 1'b0;
`ifdef MATLOAD_DBUF_EN
        staged_next = staged_reg;
`endif
        case (state_reg)
            LOAD: begin
                if (frame_done) begin
                    take_new   = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
`ifdef MATLOAD_DBUF_EN
                // A completed staged frame lives in the assembly registers until handed over.
                if (handshake) begin
                    if (staged_reg) begin
                        take_staged = 1'b1;
                        staged_next = 1'b0;
                    end else if (frame_done) begin
                        take_new = 1'b1;
                    end else begin
                        state_next = LOAD;
                    end
                end else if (frame_done) begin
                    staged_next = 1'b1;
                end
`else
                if (handshake) begin
                    state_next = LOAD;
                end
`endif
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD;
            a_asm_reg <= '0;
            b_asm_reg <= '0;
            out_a_reg <= '0;
            out_b_reg <= '0;
`ifdef MATLOAD_DBUF_EN
            staged_reg <= 1'b0;
`endif
        end else if (clear) begin
            // Output words are kept; only validity and the partial frame are dropped.
            state_reg <= LOAD;
`ifdef MATLOAD_DBUF_EN
            staged_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_asm_reg <= a_asm_next;
            b_asm_reg <= b_asm_next;
            if (take_new) begin
                out_a_reg <= a_asm_next;
                out_b_reg <= b_asm_next;
            end else if (take_staged) begin
                out_a_reg <= a_asm_reg;
                out_b_reg <= b_asm_reg;
            end
`ifdef MATLOAD_DBUF_EN
            staged_reg <= staged_next;
`endif
        end
    end

    assign lif.out_valid = (state_reg == HOLD);
    assign lif.out_a     = out_a_reg;
    assign lif.out_b     = out_b_reg;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Scoreboard bench for matmul_operand_loader: expected operand pairs are queued at stimulus time
// and compared on each output handshake; directed checks cover reset, backpressure, framing and abort.
module tb_matmul_operand_loader;
    import matmul_pkg::*;

`ifdef MATLOAD_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic frame_err;

    matmul_operand_loader_if lif ();

    matmul_operand_loader dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .lif       (lif),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          err_seen     = 0;
    int          err_expected = 0;
    bit          rand_done    = 1'b0;
    logic [15:0] sb [$];
    logic [15:0] sb_entry;
    logic [1:0]  fr [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Handshake happens at the next rising edge when both are high at the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) err_seen++;
            if (lif.out_valid && lif.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(1), 32'(0));
                end else begin
                    sb_entry = sb.pop_front();
                    check("sb_out_a", 32'(lif.out_a), 32'(sb_entry[15:8]));
                    check("sb_out_b", 32'(lif.out_b), 32'(sb_entry[7:0]));
                    $display("out a=0x%02h b=0x%02h", lif.out_a, lif.out_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [1:0] e, input bit last);
        int waited;
        waited = 0;
        lif.in_valid = 1'b1;
        lif.in_elem  = e;
        lif.in_last  = last;
        #0;
        while (!lif.in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (waited >= 200) check("in_ready_timeout", 32'(0), 32'(1));
        tick();
        lif.in_valid = 1'b0;
        lif.in_last  = 1'b0;
    endtask

    // Sends fr[0..n-1], in_last on index last_at; optionally queues the expected operand pair.
    task automatic send_frame(input int n, input int last_at, input bit push);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = '0;
        eb = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) ea = {ea[5:0], fr[k]};
            else       eb = {eb[5:0], fr[k]};
        end
        if (push) sb.push_back({ea, eb});
        for (int k = 0; k < n; k++) send_elem(fr[k], k == last_at);
    endtask

    task automatic load_nominal();
        fr[0] = 2'd1; fr[1] = 2'd2; fr[2] = 2'd3; fr[3] = 2'd0;
        fr[4] = 2'd2; fr[5] = 2'd1; fr[6] = 2'd0; fr[7] = 2'd3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        clear         = 1'b0;
        lif.in_valid  = 1'b0;
        lif.in_elem   = '0;
        lif.in_last   = 1'b0;
        lif.out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready",  32'(lif.in_ready),  32'(0));
        check("rst_out_valid", 32'(lif.out_valid), 32'(0));
        check("rst_out_a",     32'(lif.out_a),     32'(0));
        check("rst_out_b",     32'(lif.out_b),     32'(0));
        check("rst_frame_err", 32'(frame_err),     32'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(lif.in_ready), 32'(1));

        // Nominal frame, out_ready high: one-cycle output pulse
        lif.out_ready = 1'b1;
        load_nominal();
        send_frame(8, 7, 1'b1);
        check("nom_out_valid", 32'(lif.out_valid), 32'(1));
        check("nom_out_a",     32'(lif.out_a),     32'(8'h6C));
        check("nom_out_b",     32'(lif.out_b),     32'(8'h93));
        tick();
        check("nom_valid_drop", 32'(lif.out_valid), 32'(0));

        // Backpressure: held stable for 5 cycles
        lif.out_ready = 1'b0;
        send_frame(8, 7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(lif.out_valid), 32'(1));
            check("bp_out_a",     32'(lif.out_a),     32'(8'h6C));
            check("bp_out_b",     32'(lif.out_b),     32'(8'h93));
            check("bp_in_ready",  32'(lif.in_ready),  32'(DBUF));
            tick();
        end
        lif.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(lif.out_valid), 32'(0));
        check("bp_release_ready", 32'(lif.in_ready),  32'(1));

        // Early last on the 4th element
        send_frame(4, 3, 1'b0);
        err_expected++;
        check("early_err",   32'(frame_err),     32'(1));
        check("early_valid", 32'(lif.out_valid), 32'(0));
        tick();
        check("early_err_drop", 32'(frame_err), 32'(0));
        send_frame(8, 7, 1'b1);
        check("after_early_a", 32'(lif.out_a), 32'(8'h6C));
        check("after_early_b", 32'(lif.out_b), 32'(8'h93));
        tick();

        // Missing last: 8 elements without in_last
        send_frame(8, -1, 1'b0);
        err_expected++;
        check("miss_err",   32'(frame_err),     32'(1));
        check("miss_valid", 32'(lif.out_valid), 32'(0));
        send_frame(8, 7, 1'b1);
        check("after_miss_a", 32'(lif.out_a), 32'(8'h6C));
        check("after_miss_b", 32'(lif.out_b), 32'(8'h93));
        tick();

        // clear after 5 elements, then a frame of all 3s
        fr = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        send_frame(5, -1, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_out_a_kept", 32'(lif.out_a), 32'(8'h6C));
        fr = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        send_frame(8, 7, 1'b1);
        check("clr_frame_a", 32'(lif.out_a), 32'(8'hFF));
        check("clr_frame_b", 32'(lif.out_b), 32'(8'hFF));
        tick();

        // clear coinciding with the final accept discards the frame
        load_nominal();
        send_frame(7, -1, 1'b0);
        clear = 1'b1;
        send_elem(fr[7], 1'b1);
        clear = 1'b0;
        check("clr_last_valid", 32'(lif.out_valid), 32'(0));
        check("clr_last_err",   32'(frame_err),     32'(0));
        tick();

        // rst while in HOLD
        lif.out_ready = 1'b0;
        send_frame(8, 7, 1'b1);
        check("hold_valid", 32'(lif.out_valid), 32'(1));
        rst = 1'b1;
        tick();
        check("hold_rst_valid",    32'(lif.out_valid), 32'(0));
        check("hold_rst_a",        32'(lif.out_a),     32'(0));
        check("hold_rst_b",        32'(lif.out_b),     32'(0));
        check("hold_rst_in_ready", 32'(lif.in_ready),  32'(0));
        sb.delete();
        rst = 1'b0;
        lif.out_ready = 1'b1;
        tick();
        check("hold_rst_recover", 32'(lif.in_ready), 32'(1));

`ifdef MATLOAD_DBUF_EN
        // Staged frame handed over on the output handshake without a valid gap
        lif.out_ready = 1'b0;
        load_nominal();
        send_frame(8, 7, 1'b1);
        fr = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0, 2'd3, 2'd0};
        send_frame(8, 7, 1'b1);
        check("dbuf_staged_ready", 32'(lif.in_ready), 32'(0));
        lif.out_ready = 1'b1;
        tick();
        check("dbuf_b2b_valid", 32'(lif.out_valid), 32'(1));
        check("dbuf_b2b_a",     32'(lif.out_a),     32'(8'h33));
        check("dbuf_b2b_b",     32'(lif.out_b),     32'(8'hCC));
        tick();
        check("dbuf_drain_valid", 32'(lif.out_valid), 32'(0));
`endif

        // Random frames with random backpressure and occasional early last
        fork
            begin
                while (!rand_done) begin
                    tick();
                    lif.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int f = 0; f < 10; f++) begin
            int kind;
            int cut;
            for (int k = 0; k < 8; k++) fr[k] = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                cut = $urandom_range(0, 6);
                send_frame(cut + 1, cut, 1'b0);
                err_expected++;
            end else begin
                send_frame(8, 7, 1'b1);
            end
        end
        rand_done = 1'b1;
        tick();
        lif.out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        repeat (3) tick();
        check("sb_drained",  32'(sb.size()), 32'(0));
        check("err_pulses",  32'(err_seen),  32'(err_expected));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/matmul_operand_loader.md
Name: matmul_operand_loader

Overview:
Upstream stage of the 2x2 matrix multiplier. It accepts a serial stream of 2-bit matrix elements over a valid/ready handshake and assembles one frame of 8 elements (matrix A, then matrix B). It then presents the packed A and B words, in the multiplier's packing order, behind a valid/ready output handshake. It checks frame delimiting and flags malformed frames.

Parameters:
ELEM_W, 2, element width in bits; must match the multiplier operand element width.
NUM_ELEMS, 8, elements per frame (4 for A, 4 for B); fixed for 2x2 operation.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
clear  in  1  synchronous abort: discard the partial frame and the held output.
in_valid  in  1  input element valid.
in_ready  out  1  loader can accept an element.
in_elem  in  ELEM_W  element value.
in_last  in  1  marks the final (8th) element of a frame.
out_valid  out  1  packed operands valid.
out_ready  in  1  multiplier side accepts operands.
out_a  out  4*ELEM_W  packed {a11,a12,a21,a22}, a11 in MSBs.
out_b  out  4*ELEM_W  packed {b11,b12,b21,b22}, b11 in MSBs.
frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Single clock domain: clk only. rst is synchronous, active-high.
- Reset (rst high at a rising edge):
  - state=LOAD, count=0.
  - out_valid=0, out_a=0, out_b=0, frame_err=0.
  - in_ready is forced to 0 while rst is high.
- Element accept: occurs on a cycle with in_valid && in_ready.
- Element ordering: element index k=count (0..7).
  - k 0..3 go to the A assembly register, k 4..7 go to B.
  - Within a matrix, j=k%4 is written to bits [4*ELEM_W-1-j*ELEM_W -: ELEM_W].
- FSM states: LOAD, HOLD.
- LOAD:
  - in_ready=1. Each accept writes the slot and increments count.
  - Accept with in_last=1 and count!=7: frame_err pulses next cycle, count→0, partial frame discarded, stay LOAD.
  - Accept with count==7 and in_last=0: same error handling.
  - Accept with count==7 and in_last=1: assembled A/B are copied to out_a/out_b, out_valid=1 from the next cycle, count→0, state→HOLD.
  - Latency: 1 cycle from the 8th element accept to out_valid.
- HOLD:
  - in_ready=0. out_valid stays 1; out_a/out_b are stable.
  - On out_valid && out_ready: out_valid=0 next cycle, state→LOAD.
  - Throughput without the optional feature is at most 1 frame per 9 cycles.
- Validity rules:
  - out_valid never drops without a completed handshake, except on clear or rst.
  - in_elem and in_last are ignored when not accepted.
- clear: has priority over all events except rst. Same next-state effect as rst, except out_a/out_b keep their value and frame_err=0.
- Simultaneous events: clear together with a final-element accept means the frame is discarded.
- Reset mid-frame or in HOLD: everything is abandoned. No partial output is ever emitted.

Optional Feature:
Macro MATLOAD_DBUF_EN.
- Defined:
  - Adds a staging buffer, so in_ready stays 1 in HOLD while the next frame assembles.
  - If the staged frame completes while the output is still unaccepted, in_ready=0 until the output handshake.
  - On the output handshake with a complete staged frame, the staged frame moves to out_a/out_b in that same transfer and out_valid remains 1 (back-to-back frames, 1 frame per 8 cycles sustained).
  - clear and rst also empty the staging buffer.
- Undefined: behaviour is exactly as above, with in_ready=0 in HOLD.

Decomposition:
- Shared package matmul_pkg holds:
  - ELEM_W, NUM_ELEMS and MAT_W=4*ELEM_W constants.
  - The loader state enum {LOAD, HOLD}.
  - A function elem_offset(k) returning the bit offset of element k within its matrix word.
- One natural sub-module, matload_frame_ctrl, owns the element counter, in_last framing check and frame_err generation. The top module owns the data registers and the output handshake.

Test Plan:
- Nominal frame: elements 1,2,3,0,2,1,0,3 with in_last on the 8th, out_ready=1 → out_a=0x6C and out_b=0x93 one cycle after the last accept; out_valid high for exactly 1 cycle.
- Backpressure: same frame with out_ready=0 for 5 cycles → out_valid, out_a=0x6C and out_b=0x93 stable all 5 cycles, in_ready=0 (undefined macro); release → out_valid=0 next cycle, in_ready=1.
- Early last: in_last on the 4th element → frame_err=1 for one cycle, no out_valid; the following nominal frame produces 0x6C/0x93 correctly.
- Missing last: 8 elements with in_last=0 → frame_err pulse, no output; count back to 0.
- clear after 5 elements, then a full frame of all 3s → out_a=out_b=0xFF, no residue from the aborted frame.
- rst asserted while in HOLD → out_valid=0, out_a=out_b=0 next cycle; with MATLOAD_DBUF_EN, two back-to-back frames with out_ready=1 → out_valid continuous, second frame presented on the handshake cycle.
